// File: rtl/data_bus_responder_if.sv
// data_bus_responder_if: core data bus plus GPIO and transmit stream signals of the responder
interface data_bus_responder_if;
  logic [31:0] addr, wd, rd, gpio_out;
  logic        we, tx_valid, tx_ready;
  logic [7:0]  tx_data;
  modport master (output addr, we, wd, tx_ready, input rd, gpio_out, tx_data, tx_valid);
  modport slave  (input addr, we, wd, tx_ready, output rd, gpio_out, tx_data, tx_valid);
endinterface

// File: rtl/data_bus_responder.sv
// data_bus_responder: word RAM plus memory-mapped cycle counter, GPIO and transmit FIFO
module data_bus_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input logic clk,
  input logic reset,
  data_bus_responder_if.slave bus
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0]   r_ram [RAM_WORDS];
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [31:0]   r_cycle, r_gpio;
  logic [PW-1:0] r_rp, r_wp;
  logic [PW:0]   r_count;
  logic          r_ovf;
  logic [31:0]   w_base;
  logic          w_ram, w_cyc, w_gpio, w_tx, w_st, w_empty, w_full, w_push, w_pop;
  assign w_base  = {bus.addr[31:2], 2'b00};
  assign w_ram   = bus.addr < 32'(RAM_WORDS * 4);
  assign w_cyc   = w_base == 32'hFFFF_0000;
  assign w_gpio  = w_base == 32'hFFFF_0004;
  assign w_tx    = w_base == 32'hFFFF_0008;
  assign w_st    = w_base == 32'hFFFF_000C;
  assign w_empty = r_count == '0;
  assign w_full  = r_count == (PW+1)'(FIFO_DEPTH);
  // push is judged against the pre-edge count, so a full FIFO drops even with a concurrent pop
  assign w_push  = bus.we && w_tx && !w_full;
  assign w_pop   = !w_empty && bus.tx_ready;
  assign bus.rd = w_ram  ? r_ram[bus.addr[AW+1:2]] :
                  w_cyc  ? r_cycle :
                  w_gpio ? r_gpio :
                  w_st   ? {16'h0, 8'(r_count), 5'h0, r_ovf, w_full, w_empty} : 32'h0;
  assign bus.gpio_out = r_gpio;
  assign bus.tx_valid = !w_empty;
  assign bus.tx_data  = w_empty ? 8'h0 : r_fifo[r_rp];
  always_ff @(posedge clk) begin
    if (bus.we && w_ram) r_ram[bus.addr[AW+1:2]] <= bus.wd;
    if (w_push) r_fifo[r_wp] <= bus.wd[7:0];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cycle <= '0;
      r_gpio  <= '0;
      r_rp    <= '0;
      r_wp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_cycle <= (bus.we && w_cyc) ? bus.wd : r_cycle + 32'd1;
      if (bus.we && w_gpio) r_gpio <= bus.wd;
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
      if (bus.we && w_tx && w_full) r_ovf <= 1'b1;
      else if (bus.we && w_st && bus.wd[2]) r_ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder: vector table, directed FIFO sequences and random traffic vs a queue model
module tb_data_bus_responder;
  localparam int DEPTH = 8;
  localparam logic [31:0] CYC = 32'hFFFF_0000, GPIO = 32'hFFFF_0004, TX = 32'hFFFF_0008, ST = 32'hFFFF_000C;
  logic clk = 1'b0, reset;
  always #5 clk = ~clk;
  data_bus_responder_if bus();
  data_bus_responder #(.RAM_WORDS(64), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] rd;
    logic [31:0] gpio;
  } vec_t;
  vec_t vecs[$];
  int n_pass = 0, n_total = 0;
  logic [31:0] m_ram [64];
  logic [31:0] m_cyc, m_gpio;
  logic [7:0]  m_q[$];
  logic        m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d, input logic rdy);
    bus.addr = a; bus.we = w; bus.wd = d; bus.tx_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    drive(TX, 1'b1, {24'h0, b}, 1'b0);
    tick();
  endtask

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    logic [31:0] b = {a[31:2], 2'b00};
    if (a < 256) return m_ram[a[7:2]];
    if (b == CYC) return m_cyc;
    if (b == GPIO) return m_gpio;
    if (b == ST) return {16'h0, 8'(m_q.size()), 5'h0, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
    return 32'h0;
  endfunction

  task automatic m_edge(input logic [31:0] a, input logic w, input logic [31:0] d, input logic rdy);
    logic [31:0] b = {a[31:2], 2'b00};
    bit full = m_q.size() == DEPTH;
    if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
    if (w && b == TX) begin
      if (full) m_ovf = 1'b1;
      else m_q.push_back(d[7:0]);
    end else if (w && b == ST && d[2]) m_ovf = 1'b0;
    if (w && a < 256) m_ram[a[7:2]] = d;
    if (w && b == GPIO) m_gpio = d;
    m_cyc = (w && b == CYC) ? d : m_cyc + 32'd1;
  endtask

  task automatic mcycle(input logic [31:0] a, input logic w, input logic [31:0] d, input logic rdy);
    logic [7:0] head = m_q.size() != 0 ? m_q[0] : 8'h0;
    drive(a, w, d, rdy);
    check("rand_rd", bus.rd, m_rd(a));
    check("rand_tx", {23'h0, bus.tx_valid, bus.tx_data}, {23'h0, m_q.size() != 0, head});
    check("rand_gpio", bus.gpio_out, m_gpio);
    tick();
    m_edge(a, w, d, rdy);
  endtask

  initial begin
    bus.addr = '0; bus.we = 1'b0; bus.wd = '0; bus.tx_ready = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    // row index equals the counter value until row 12 reloads it
    vecs.push_back('{CYC,     1'b0, 32'h0,        1'b1, 32'h0,        32'h0});
    vecs.push_back('{CYC,     1'b0, 32'h0,        1'b1, 32'h1,        32'h0});
    vecs.push_back('{CYC,     1'b0, 32'h0,        1'b1, 32'h2,        32'h0});
    vecs.push_back('{CYC,     1'b0, 32'h0,        1'b1, 32'h3,        32'h0});
    vecs.push_back('{ST,      1'b0, 32'h0,        1'b1, 32'h1,        32'h0});
    vecs.push_back('{32'h10,  1'b1, 32'h12345678, 1'b0, 32'h0,        32'h0});
    vecs.push_back('{32'h10,  1'b1, 32'hDEADBEEF, 1'b1, 32'h12345678, 32'h0});
    vecs.push_back('{32'h10,  1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{32'h13,  1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 32'h0});
    vecs.push_back('{32'h100, 1'b0, 32'h0,        1'b1, 32'h0,        32'h0});
    vecs.push_back('{GPIO,    1'b1, 32'hA5,       1'b1, 32'h0,        32'h0});
    vecs.push_back('{GPIO,    1'b0, 32'h0,        1'b1, 32'hA5,       32'hA5});
    vecs.push_back('{CYC,     1'b1, 32'hFFFFFFFE, 1'b1, 32'hC,        32'hA5});
    vecs.push_back('{CYC,     1'b0, 32'h0,        1'b1, 32'hFFFFFFFE, 32'hA5});
    vecs.push_back('{CYC,     1'b0, 32'h0,        1'b1, 32'hFFFFFFFF, 32'hA5});
    vecs.push_back('{CYC,     1'b0, 32'h0,        1'b1, 32'h0,        32'hA5});
    vecs.push_back('{TX,      1'b0, 32'h0,        1'b1, 32'h0,        32'hA5});
    vecs.push_back('{32'h210, 1'b1, 32'h1234,     1'b1, 32'h0,        32'hA5});
    vecs.push_back('{32'hFFFF0010, 1'b0, 32'h0,   1'b1, 32'h0,        32'hA5});
    vecs.push_back('{32'h10,  1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 32'hA5});
    foreach (vecs[i]) begin
      drive(vecs[i].addr, vecs[i].we, vecs[i].wd, 1'b0);
      if (vecs[i].chk) check($sformatf("vec%0d_rd", i), bus.rd, vecs[i].rd);
      check($sformatf("vec%0d_gpio", i), bus.gpio_out, vecs[i].gpio);
      check($sformatf("vec%0d_txv", i), {31'h0, bus.tx_valid}, 32'h0);
      tick();
    end
    // in-order drain
    push(8'h41);
    check("push_empty_valid", {31'h0, bus.tx_valid}, 32'h1);
    push(8'h42);
    push(8'h43);
    drive(ST, 1'b0, 32'h0, 1'b0);
    check("status_3", bus.rd, 32'h300);
    for (int i = 0; i < 3; i++) begin
      drive(ST, 1'b0, 32'h0, 1'b1);
      check($sformatf("drain_%0d", i), {23'h0, bus.tx_valid, bus.tx_data}, 32'h141 + 32'(i));
      tick();
    end
    drive(ST, 1'b0, 32'h0, 1'b1);
    check("drained_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("drained_status", bus.rd, 32'h1);
    // overflow then clear
    for (int i = 1; i <= 9; i++) push(8'(i));
    drive(ST, 1'b0, 32'h0, 1'b0);
    check("status_ovf", bus.rd, 32'h806);
    drive(ST, 1'b1, 32'h4, 1'b0);
    tick();
    drive(ST, 1'b0, 32'h0, 1'b0);
    check("status_clr", bus.rd, 32'h802);
    for (int i = 1; i <= 8; i++) begin
      drive(ST, 1'b0, 32'h0, 1'b1);
      check($sformatf("ovf_drain_%0d", i), {24'h0, bus.tx_data}, 32'(i));
      tick();
    end
    drive(ST, 1'b0, 32'h0, 1'b0);
    check("ovf_drained_status", bus.rd, 32'h1);
    // simultaneous push and pop at count 3
    push(8'h10);
    push(8'h20);
    push(8'h30);
    drive(TX, 1'b1, 32'h40, 1'b1);
    check("pp_head", {24'h0, bus.tx_data}, 32'h10);
    tick();
    drive(ST, 1'b0, 32'h0, 1'b0);
    check("pp_status", bus.rd, 32'h300);
    for (int i = 0; i < 3; i++) begin
      drive(ST, 1'b0, 32'h0, 1'b1);
      check($sformatf("pp_drain_%0d", i), {24'h0, bus.tx_data}, 32'h20 + 32'(i) * 32'h10);
      tick();
    end
    drive(ST, 1'b0, 32'h0, 1'b0);
    check("pp_empty", bus.rd, 32'h1);
    // reset mid-drain
    push(8'h50);
    push(8'h60);
    push(8'h70);
    drive(ST, 1'b0, 32'h0, 1'b1);
    check("rst_head", {24'h0, bus.tx_data}, 32'h50);
    tick();
    reset = 1'b0;
    drive(ST, 1'b0, 32'h0, 1'b1);
    tick();
    reset = 1'b1;
    drive(ST, 1'b0, 32'h0, 1'b0);
    check("rst_valid", {31'h0, bus.tx_valid}, 32'h0);
    check("rst_status", bus.rd, 32'h1);
    check("rst_gpio", bus.gpio_out, 32'h0);
    // random traffic against the model
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    m_cyc = 32'h0; m_gpio = 32'h0; m_ovf = 1'b0; m_q.delete();
    for (int i = 0; i < 64; i++) begin
      logic [31:0] d = $urandom;
      drive(32'(i * 4), 1'b1, d, 1'b0);
      tick();
      m_edge(32'(i * 4), 1'b1, d, 1'b0);
    end
    for (int i = 0; i < 1500; i++) begin
      int k = $urandom_range(0, 7);
      logic [31:0] a;
      logic rdy;
      a = (k < 2) ? 32'($urandom_range(0, 255)) :
          (k == 2) ? 32'($urandom_range(256, 4095)) :
          (k == 7) ? 32'($urandom) :
          32'hFFFF_0000 + 32'((k - 3) * 4) + 32'($urandom_range(0, 3));
      rdy = ((i / 300) % 2 == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      mcycle(a, 1'($urandom_range(0, 1)), $urandom, rdy);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
